// File: rtl/codeword_scan_ctrl_pkg.sv
// Shared state encoding and default widths for the codeword scan controller.
package codeword_scan_ctrl_pkg;

   localparam int WIN_W_DEF = 16;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ARM  = 2'b01,
      SCAN = 2'b10,
      DONE = 2'b11
   } scan_state_e;

endpackage

// File: rtl/scan_window_timer.sv
// Window down-counter: loads the window length, decrements once per scan cycle,
// and flags the last cycle of the window (timer == 1).
module scan_window_timer
   import codeword_scan_ctrl_pkg::*;
#(
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIN_W-1:0] load_val,
   input  logic             dec,
   output logic [WIN_W-1:0] timer,
   output logic             last
);

   logic [WIN_W-1:0] timer_q, timer_d;

   always_comb begin
      timer_d = timer_q;
      if (load) begin
         timer_d = load_val;
      end else if (dec && (timer_q != '0)) begin
         timer_d = timer_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign timer = timer_q;
   assign last  = (timer_q == WIN_W'(1));

endmodule

// File: rtl/codeword_scan_ctrl.sv
// Scan-session sequencer for one 1110-pattern detector: clear, count hits over a window,
// early stop on threshold, hold result behind valid/ready. Optional SCAN_FIRST_HIT_EN adds res_first.
//
// state | meaning
// IDLE  | waiting for start; last result fields still visible
// ARM   | one cycle: detector cleared, window timer loaded
// SCAN  | counting det_flag pulses until window ends or threshold reached
// DONE  | result valid, waiting for res_ready
module codeword_scan_ctrl
   import codeword_scan_ctrl_pkg::*;
#(
   parameter int WIN_W = WIN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIN_W-1:0] win_len,
   input  logic [CNT_W-1:0] threshold,
   input  logic             det_flag,
   output logic             det_clr,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_count,
   output logic             res_hit,
   output logic             res_ovf,
`ifdef SCAN_FIRST_HIT_EN
   output logic [WIN_W-1:0] res_first,
`endif
   output logic [1:0]       state
);

   scan_state_e      state_q, state_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [CNT_W-1:0] thr_q, thr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             hit_q, hit_d;
   logic             ovf_q, ovf_d;
   logic [WIN_W-1:0] timer_val;
   logic             timer_last;
   logic [CNT_W-1:0] count_inc;
   logic             cnt_sat;
   logic             hit_in;
   logic             thr_reach;
   logic             window_end;

   scan_window_timer #(.WIN_W(WIN_W)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (state_q == ARM),
      .load_val (win_q),
      .dec      (state_q == SCAN),
      .timer    (timer_val),
      .last     (timer_last)
   );

   assign count_inc  = count_q + 1'b1;
   assign cnt_sat    = &count_q;
   assign hit_in     = (state_q == SCAN) && det_flag;
   assign thr_reach  = hit_in && !cnt_sat && (thr_q != '0) && (count_inc == thr_q);
   // A zero timer in SCAN cannot occur normally; treat it as end of window rather than run forever.
   assign window_end = timer_last || (timer_val == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = ARM;
         ARM: begin
            if (abort)              state_d = IDLE;
            else if (win_q == '0)   state_d = DONE;
            else                    state_d = SCAN;
         end
         SCAN: begin
            if (abort)                        state_d = IDLE;
            else if (thr_reach || window_end) state_d = DONE;
         end
         DONE: if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != IDLE);
      det_clr   = (state_q == ARM);
      res_valid = (state_q == DONE);
      res_count = count_q;
      res_hit   = hit_q;
      res_ovf   = ovf_q;
      state     = state_q;
   end

   always_comb begin
      win_d   = win_q;
      thr_d   = thr_q;
      count_d = count_q;
      hit_d   = hit_q;
      ovf_d   = ovf_q;
      if ((state_q == IDLE) && start) begin
         win_d   = win_len;
         thr_d   = threshold;
         count_d = '0;
         hit_d   = 1'b0;
         ovf_d   = 1'b0;
      end else if (hit_in && !abort) begin
         if (cnt_sat) ovf_d   = 1'b1;
         else         count_d = count_inc;
         if (thr_reach) hit_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_q   <= '0;
         thr_q   <= '0;
         count_q <= '0;
         hit_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         win_q   <= win_d;
         thr_q   <= thr_d;
         count_q <= count_d;
         hit_q   <= hit_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef SCAN_FIRST_HIT_EN
   logic [WIN_W-1:0] first_q, first_d;

   // Scan index is how far the timer has moved from the loaded window length.
   always_comb begin
      first_d = first_q;
      if ((state_q == IDLE) && start) begin
         first_d = '1;
      end else if (hit_in && !abort && (count_q == '0) && !ovf_q) begin
         first_d = win_q - timer_val;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         first_q <= '0;
      end else begin
         first_q <= first_d;
      end
   end

   assign res_first = first_q;
`endif

endmodule
